// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants, decoder state encoding and the key event record for the
// PS/2 scan-set-2 key decoder.
package ps2_pkg;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FC = 8'hFC;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  localparam logic [2:0] PAUSE_LAST = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_E0    = 3'd1,
    ST_F0    = 3'd2,
    ST_E0F0  = 3'd3,
    ST_PAUSE = 3'd4
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       pause;
  } key_event_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == BYTE_E0) || (b == BYTE_E1) || (b == BYTE_F0);
  endfunction

  function automatic logic is_sys(input logic [7:0] b);
    return (b == BYTE_AA) || (b == BYTE_FC) || (b == BYTE_FA) || (b == BYTE_EE) ||
           (b == BYTE_FE) || (b == BYTE_00) || (b == BYTE_FF);
  endfunction

  // Bytes expected after the leading E1 of the Pause make/break sequence.
  function automatic logic [7:0] pause_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h14;
      3'd1:    return 8'h77;
      3'd2:    return BYTE_E1;
      3'd3:    return BYTE_F0;
      3'd4:    return 8'h14;
      3'd5:    return BYTE_F0;
      3'd6:    return 8'h77;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the byte input, key event output, system byte output and
// key-state query signals of the PS/2 key decoder.
interface ps2_key_decoder_if;

  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both 1; valid and its payload hold until that edge, and ready
  // never depends on valid.
  logic [7:0] rx_data;
  logic       rx_user;
  logic       rx_valid;
  logic       rx_ready;

  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_pause;
  logic       key_valid;
  logic       key_ready;

  logic [7:0] sys_code;
  logic       sys_valid;
  logic [7:0] err_count;

  logic [8:0] key_query;
  logic       key_is_down;

  logic [2:0] dbg_state;
  logic [2:0] dbg_pause_cnt;

  modport slave (
    input  rx_data, rx_user, rx_valid, key_ready, key_query,
    output rx_ready, key_code, key_ext, key_break, key_pause, key_valid,
           sys_code, sys_valid, err_count, key_is_down, dbg_state, dbg_pause_cnt
  );

  modport master (
    output rx_data, rx_user, rx_valid, key_ready, key_query,
    input  rx_ready, key_code, key_ext, key_break, key_pause, key_valid,
           sys_code, sys_valid, err_count, key_is_down, dbg_state, dbg_pause_cnt
  );

endinterface

// File: rtl/ps2_key_decoder_event_fifo.sv
// Synchronous FIFO of key events; output data reads as zero while empty so
// the event fields are clean after reset.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  key_event_t                  i_in_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output key_event_t                  o_out_data,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  key_event_t       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_in_ready  = r_count < (AW+1)'(FIFO_DEPTH);
  assign o_out_valid = r_count != '0;
  assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count     = r_count;
  assign w_wr        = i_in_valid & o_in_ready;
  assign w_rd        = o_out_valid & i_out_ready;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_in_data;
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-set-2 byte stream to key event decoder with an event FIFO.
// Optional key-down table enabled by defining PS2_KEY_STATE_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  ps2_key_decoder_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ps2_state_e r_state;
  ps2_state_e w_next_state;
  logic [2:0] r_pcnt;
  logic [2:0] w_next_pcnt;
  logic       w_accept;
  logic       w_push;
  logic       w_sys;
  logic       w_err;
  key_event_t w_evt;

  logic       r_stg_vld;
  key_event_t r_stg_evt;
  logic [7:0] r_sys_code;
  logic       r_sys_valid;
  logic [7:0] r_err_count;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occ;
  key_event_t    w_head;
  logic          w_unused_in_ready;

  // Occupancy includes the staged event, so the FIFO can always absorb it.
  assign w_occ        = w_count + CW'(r_stg_vld);
  assign bus.rx_ready = w_occ < CW'(FIFO_DEPTH);
  assign w_accept     = bus.rx_valid & bus.rx_ready;

  always_comb begin
    w_next_state = r_state;
    w_next_pcnt  = r_pcnt;
    w_push       = 1'b0;
    w_sys        = 1'b0;
    w_err        = 1'b0;
    w_evt        = '0;
    w_evt.code   = bus.rx_data;
    if (w_accept) begin
      if (bus.rx_user) begin
        w_err        = 1'b1;
        w_next_state = ST_IDLE;
        w_next_pcnt  = 3'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.rx_data == BYTE_E0) w_next_state = ST_E0;
            else if (bus.rx_data == BYTE_F0) w_next_state = ST_F0;
            else if (bus.rx_data == BYTE_E1) begin
              w_next_state = ST_PAUSE;
              w_next_pcnt  = 3'd0;
            end else if (is_sys(bus.rx_data)) w_sys = 1'b1;
            else w_push = 1'b1;
          end
          ST_E0: begin
            w_next_state = ST_IDLE;
            if (bus.rx_data == BYTE_F0) w_next_state = ST_E0F0;
            else if (is_prefix(bus.rx_data)) w_err = 1'b1;
            else begin
              w_push    = 1'b1;
              w_evt.ext = 1'b1;
            end
          end
          ST_F0, ST_E0F0: begin
            w_next_state = ST_IDLE;
            if (is_prefix(bus.rx_data)) w_err = 1'b1;
            else begin
              w_push    = 1'b1;
              w_evt.ext = (r_state == ST_E0F0);
              w_evt.brk = 1'b1;
            end
          end
          ST_PAUSE: begin
            if (bus.rx_data != pause_byte(r_pcnt)) begin
              w_err        = 1'b1;
              w_next_state = ST_IDLE;
              w_next_pcnt  = 3'd0;
            end else if (r_pcnt == PAUSE_LAST) begin
              w_push       = 1'b1;
              w_evt.pause  = 1'b1;
              w_next_state = ST_IDLE;
              w_next_pcnt  = 3'd0;
            end else begin
              w_next_pcnt = r_pcnt + 3'd1;
            end
          end
          default: begin
            w_next_state = ST_IDLE;
            w_next_pcnt  = 3'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pcnt      <= 3'd0;
      r_stg_vld   <= 1'b0;
      r_stg_evt   <= '0;
      r_sys_code  <= 8'h00;
      r_sys_valid <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_state     <= w_next_state;
      r_pcnt      <= w_next_pcnt;
      r_stg_vld   <= w_push;
      r_stg_evt   <= w_evt;
      r_sys_valid <= w_sys;
      if (w_sys) r_sys_code <= bus.rx_data;
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (r_stg_vld),
    .o_in_ready  (w_unused_in_ready),
    .i_in_data   (r_stg_evt),
    .o_out_valid (bus.key_valid),
    .i_out_ready (bus.key_ready),
    .o_out_data  (w_head),
    .o_count     (w_count)
  );

  assign bus.key_code      = w_head.code;
  assign bus.key_ext       = w_head.ext;
  assign bus.key_break     = w_head.brk;
  assign bus.key_pause     = w_head.pause;
  assign bus.sys_code      = r_sys_code;
  assign bus.sys_valid     = r_sys_valid;
  assign bus.err_count     = r_err_count;
  assign bus.dbg_state     = r_state;
  assign bus.dbg_pause_cnt = r_pcnt;

`ifdef PS2_KEY_STATE_EN
  logic [511:0] r_key_tbl;
  logic         r_key_down;

  // Table follows events as they are decoded, ahead of the consumer popping them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_tbl  <= '0;
      r_key_down <= 1'b0;
    end else begin
      if (w_push && !w_evt.pause) r_key_tbl[{w_evt.ext, w_evt.code}] <= !w_evt.brk;
      r_key_down <= r_key_tbl[bus.key_query];
    end
  end

  assign bus.key_is_down = r_key_down;
`else
  logic w_unused_query;
  assign w_unused_query  = ^bus.key_query;
  assign bus.key_is_down = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (FIFO_DEPTH = 4).
module tb_ps2_key_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef PS2_KEY_STATE_EN
  localparam logic KS = 1'b1;
`else
  localparam logic KS = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [10:0] exp_q[$];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_user = 1'b0;
    bus.key_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic user);
    int n = 0;
    bus.rx_data = b;
    bus.rx_user = user;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) begin
      total_cnt++;
      $display("FAIL send_timeout byte=%h rx_ready=0 required=1", b);
      bus.rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_user = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_event(output logic [10:0] ev);
    int n = 0;
    while (!bus.key_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.key_valid) begin
      ev = 11'h7FF;
      return;
    end
    ev = {bus.key_code, bus.key_ext, bus.key_break, bus.key_pause};
    bus.key_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.key_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (bus.rx_ready !== 1'b1) $display("FAIL rst_rx_ready got=%b exp=1", bus.rx_ready); else pass_cnt++;
    total_cnt++; if (bus.key_valid !== 1'b0) $display("FAIL rst_key_valid got=%b exp=0", bus.key_valid); else pass_cnt++;
    total_cnt++; if (bus.sys_valid !== 1'b0) $display("FAIL rst_sys_valid got=%b exp=0", bus.sys_valid); else pass_cnt++;
    total_cnt++; if (bus.sys_code !== 8'h00) $display("FAIL rst_sys_code got=%h exp=00", bus.sys_code); else pass_cnt++;
    total_cnt++; if ({bus.key_code, bus.key_ext, bus.key_break, bus.key_pause} !== 11'h000)
      $display("FAIL rst_key_fields got=%h exp=000", {bus.key_code, bus.key_ext, bus.key_break, bus.key_pause}); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 8'h00) $display("FAIL rst_err_count got=%h exp=00", bus.err_count); else pass_cnt++;
    total_cnt++; if (bus.key_is_down !== 1'b0) $display("FAIL rst_key_is_down got=%b exp=0", bus.key_is_down); else pass_cnt++;
    total_cnt++; if (bus.dbg_state !== 3'd0) $display("FAIL rst_state got=%0d exp=0", bus.dbg_state); else pass_cnt++;
  endtask

  task automatic test_make_break();
    logic [10:0] ev;
    do_reset();
    bus.key_query = 9'h01C;
    send_byte(8'h1C, 1'b0);
    total_cnt++; if (bus.key_valid !== 1'b0) $display("FAIL mb_latency_early got=%b exp=0", bus.key_valid); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (bus.key_valid !== 1'b1) $display("FAIL mb_latency_valid got=%b exp=1", bus.key_valid); else pass_cnt++;
    total_cnt++; if (bus.key_code !== 8'h1C) $display("FAIL mb_latency_code got=%h exp=1c", bus.key_code); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.key_is_down !== KS) $display("FAIL mb_down_after_make got=%b exp=%b", bus.key_is_down, KS); else pass_cnt++;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    total_cnt++; if (bus.key_is_down !== KS) $display("FAIL mb_down_registered got=%b exp=%b", bus.key_is_down, KS); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.key_is_down !== 1'b0) $display("FAIL mb_down_after_break got=%b exp=0", bus.key_is_down); else pass_cnt++;
    pop_event(ev);
    total_cnt++; if (ev !== {8'h1C, 3'b000}) $display("FAIL mb_make_event got=%h exp=%h", ev, {8'h1C, 3'b000}); else pass_cnt++;
    pop_event(ev);
    total_cnt++; if (ev !== {8'h1C, 3'b010}) $display("FAIL mb_break_event got=%h exp=%h", ev, {8'h1C, 3'b010}); else pass_cnt++;
  endtask

  task automatic test_extended();
    logic [10:0] ev;
    do_reset();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    total_cnt++; if (bus.dbg_state !== 3'd3) $display("FAIL ext_state_e0f0 got=%0d exp=3", bus.dbg_state); else pass_cnt++;
    send_byte(8'h75, 1'b0);
    pop_event(ev);
    total_cnt++; if (ev !== {8'h75, 3'b100}) $display("FAIL ext_make_event got=%h exp=%h", ev, {8'h75, 3'b100}); else pass_cnt++;
    pop_event(ev);
    total_cnt++; if (ev !== {8'h75, 3'b110}) $display("FAIL ext_break_event got=%h exp=%h", ev, {8'h75, 3'b110}); else pass_cnt++;
  endtask

  task automatic test_pause();
    logic [10:0] ev;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0);
    pop_event(ev);
    total_cnt++; if (ev !== {8'h77, 3'b001}) $display("FAIL pause_event got=%h exp=%h", ev, {8'h77, 3'b001}); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.key_valid !== 1'b0) $display("FAIL pause_single got=%b exp=0", bus.key_valid); else pass_cnt++;
    send_byte(8'hE1, 1'b0);
    send_byte(8'h14, 1'b0);
    total_cnt++; if (bus.dbg_pause_cnt !== 3'd1) $display("FAIL pause_cnt got=%0d exp=1", bus.dbg_pause_cnt); else pass_cnt++;
    send_byte(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.err_count !== 8'h01) $display("FAIL pause_mismatch_err got=%h exp=01", bus.err_count); else pass_cnt++;
    total_cnt++; if (bus.key_valid !== 1'b0) $display("FAIL pause_mismatch_noevt got=%b exp=0", bus.key_valid); else pass_cnt++;
    total_cnt++; if (bus.dbg_state !== 3'd0) $display("FAIL pause_mismatch_idle got=%0d exp=0", bus.dbg_state); else pass_cnt++;
  endtask

  task automatic test_sys();
    do_reset();
    send_byte(8'hAA, 1'b0);
    total_cnt++; if ({bus.sys_valid, bus.sys_code} !== {1'b1, 8'hAA}) $display("FAIL sys_aa got=%h exp=1aa", {bus.sys_valid, bus.sys_code}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.sys_valid !== 1'b0) $display("FAIL sys_pulse_width got=%b exp=0", bus.sys_valid); else pass_cnt++;
    send_byte(8'hFA, 1'b0);
    total_cnt++; if ({bus.sys_valid, bus.sys_code} !== {1'b1, 8'hFA}) $display("FAIL sys_fa got=%h exp=1fa", {bus.sys_valid, bus.sys_code}); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.key_valid !== 1'b0) $display("FAIL sys_no_key got=%b exp=0", bus.key_valid); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 8'h00) $display("FAIL sys_no_err got=%h exp=00", bus.err_count); else pass_cnt++;
  endtask

  task automatic test_rx_user();
    logic [10:0] ev;
    do_reset();
    send_byte(8'hF0, 1'b1);
    send_byte(8'h1C, 1'b0);
    pop_event(ev);
    total_cnt++; if (ev !== {8'h1C, 3'b000}) $display("FAIL user_event got=%h exp=%h", ev, {8'h1C, 3'b000}); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 8'h01) $display("FAIL user_err got=%h exp=01", bus.err_count); else pass_cnt++;
  endtask

  task automatic test_err_saturate();
    do_reset();
    for (int i = 0; i < 260; i++) send_byte(8'(i), 1'b1);
    total_cnt++; if (bus.err_count !== 8'hFF) $display("FAIL err_saturate got=%h exp=ff", bus.err_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] ev;
    do_reset();
    send_byte(8'h1C, 1'b0);
    send_byte(8'hE0, 1'b0);
    total_cnt++; if (bus.dbg_state !== 3'd1) $display("FAIL mid_state_e0 got=%0d exp=1", bus.dbg_state); else pass_cnt++;
    do_reset();
    total_cnt++; if (bus.key_valid !== 1'b0) $display("FAIL mid_flush got=%b exp=0", bus.key_valid); else pass_cnt++;
    total_cnt++; if (bus.dbg_state !== 3'd0) $display("FAIL mid_state_idle got=%0d exp=0", bus.dbg_state); else pass_cnt++;
    send_byte(8'h75, 1'b0);
    pop_event(ev);
    total_cnt++; if (ev !== {8'h75, 3'b000}) $display("FAIL mid_event got=%h exp=%h", ev, {8'h75, 3'b000}); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 8'h00) $display("FAIL mid_err got=%h exp=00", bus.err_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [5];
    logic [10:0] got [5];
    logic [10:0] ev;
    logic [10:0] exp_ev;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back({codes[i], 3'b000});
    for (int i = 0; i < 4; i++) send_byte(codes[i], 1'b0);
    total_cnt++; if (bus.rx_ready !== 1'b0) $display("FAIL b2b_full_ready got=%b exp=0", bus.rx_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.rx_ready !== 1'b0) $display("FAIL b2b_full_hold got=%b exp=0", bus.rx_ready); else pass_cnt++;
    total_cnt++; if (bus.key_code !== 8'h15) $display("FAIL b2b_head_stable got=%h exp=15", bus.key_code); else pass_cnt++;
    fork
      send_byte(codes[4], 1'b0);
      begin
        for (int i = 0; i < 5; i++) begin
          pop_event(ev);
          got[i] = ev;
        end
      end
    join
    for (int i = 0; i < 5; i++) begin
      exp_ev = exp_q.pop_front();
      total_cnt++; if (got[i] !== exp_ev) $display("FAIL b2b_order_%0d got=%h exp=%h", i, got[i], exp_ev); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (bus.key_valid !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", bus.key_valid); else pass_cnt++;
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_user = 1'b0;
    bus.rx_valid = 1'b0;
    bus.key_ready = 1'b0;
    bus.key_query = 9'h000;
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_sys();
    test_rx_user();
    test_err_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
